// File: rtl/write_address_verifier.sv
// Checks that accepted Avalon-MM write beats follow base, base+STRIDE, ... for a configured count.
// Optional WAV_OVERRUN_CHECK_EN: an accepted beat after completion is reported as an error.
module write_address_verifier #(
    parameter int ADDR_W = 32,
    parameter int STRIDE = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] io_cfg_base,
    input  logic [CNT_W-1:0]  io_cfg_count,
    input  logic              io_start,
    input  logic [ADDR_W-1:0] io_mon_address,
    input  logic              io_mon_write,
    input  logic              io_mon_waitrequest,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_error,
    output logic [ADDR_W-1:0] io_errAddr,
    output logic [CNT_W-1:0]  io_errIndex,
    output logic [4:0]        io___dbgInfo
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DONE  = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  index_q, index_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  err_index_q, err_index_d;
    logic [ADDR_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              busy_q, done_q, error_q;
    logic [4:0]        dbg_q;

    logic              accept;
    logic [CNT_W-1:0]  index_inc;

    assign accept    = io_mon_write && !io_mon_waitrequest;
    assign index_inc = index_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        count_d     = count_q;
        exp_d       = exp_q;
        err_addr_d  = err_addr_q;
        err_index_d = err_index_q;
        unique case (state_q)
            S_RUN: begin
                // Start is ignored while a run is in progress.
                if (accept) begin
                    if (io_mon_address == exp_q) begin
                        index_d = index_inc;
                        exp_d   = exp_q + ADDR_W'(STRIDE);
                        if (index_inc == count_q) state_d = S_DONE;
                    end else begin
                        state_d     = S_ERROR;
                        err_addr_d  = io_mon_address;
                        err_index_d = index_q;
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERROR all re-arm identically; a beat in the start cycle is not checked.
                if (io_start) begin
                    count_d     = io_cfg_count;
                    index_d     = '0;
                    exp_d       = io_cfg_base;
                    err_addr_d  = '0;
                    err_index_d = '0;
                    state_d     = (io_cfg_count == '0) ? S_DONE : S_RUN;
                end
`ifdef WAV_OVERRUN_CHECK_EN
                else if (state_q == S_DONE && accept) begin
                    state_d     = S_ERROR;
                    err_addr_d  = io_mon_address;
                    err_index_d = count_q;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            count_q     <= '0;
            exp_q       <= '0;
            err_addr_q  <= '0;
            err_index_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            dbg_q       <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            count_q     <= count_d;
            exp_q       <= exp_d;
            err_addr_q  <= err_addr_d;
            err_index_q <= err_index_d;
            // Flags and status code are flopped from next-state so outputs come straight from registers.
            busy_q      <= (state_d == S_RUN);
            done_q      <= (state_d == S_DONE);
            error_q     <= (state_d == S_ERROR);
            dbg_q       <= {state_d, index_d[2:0]};
        end
    end

    assign io_busy      = busy_q;
    assign io_done      = done_q;
    assign io_error     = error_q;
    assign io_errAddr   = err_addr_q;
    assign io_errIndex  = err_index_q;
    assign io___dbgInfo = dbg_q;

endmodule

// File: tb/tb_write_address_verifier.sv
// Randomized + directed bench for write_address_verifier against an arithmetic reference model.
module tb_write_address_verifier;

    localparam int ADDR_W = 32;
    localparam int STRIDE = 8;
    localparam int CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] io_cfg_base = '0;
    logic [CNT_W-1:0]  io_cfg_count = '0;
    logic              io_start = 1'b0;
    logic [ADDR_W-1:0] io_mon_address = '0;
    logic              io_mon_write = 1'b0;
    logic              io_mon_waitrequest = 1'b0;
    logic              io_busy, io_done, io_error;
    logic [ADDR_W-1:0] io_errAddr;
    logic [CNT_W-1:0]  io_errIndex;
    logic [4:0]        io___dbgInfo;

    int n_cmp = 0;
    int n_err = 0;

    write_address_verifier #(.ADDR_W(ADDR_W), .STRIDE(STRIDE), .CNT_W(CNT_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_cfg_base        (io_cfg_base),
        .io_cfg_count       (io_cfg_count),
        .io_start           (io_start),
        .io_mon_address     (io_mon_address),
        .io_mon_write       (io_mon_write),
        .io_mon_waitrequest (io_mon_waitrequest),
        .io_busy            (io_busy),
        .io_done            (io_done),
        .io_error           (io_error),
        .io_errAddr         (io_errAddr),
        .io_errIndex        (io_errIndex),
        .io___dbgInfo       (io___dbgInfo)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 idle, 1 run, 2 done, 3 error; m_n beats matched so far.
    int          m_state = 0;
    logic [31:0] m_base  = '0;
    int          m_count = 0;
    int          m_n     = 0;
    logic [31:0] m_ea    = '0;
    int          m_ei    = 0;

    function automatic logic [31:0] model_exp();
        return m_base + 32'(m_n * STRIDE);
    endfunction

    function automatic logic [4:0] model_dbg();
        logic [1:0] s;
        logic [2:0] n;
        s = 2'(m_state);
        n = 3'(m_n);
        return {s, n};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state <= 0; m_base <= '0; m_count <= 0; m_n <= 0; m_ea <= '0; m_ei <= 0;
        end else if (io_start && m_state != 1) begin
            m_base  <= io_cfg_base;
            m_count <= int'(io_cfg_count);
            m_n     <= 0;
            m_ea    <= '0;
            m_ei    <= 0;
            m_state <= (io_cfg_count == 0) ? 2 : 1;
        end else if (m_state == 1 && io_mon_write && !io_mon_waitrequest) begin
            if (io_mon_address == model_exp()) begin
                m_n <= m_n + 1;
                if (m_n + 1 == m_count) m_state <= 2;
            end else begin
                m_state <= 3;
                m_ea    <= io_mon_address;
                m_ei    <= m_n;
            end
        end
`ifdef WAV_OVERRUN_CHECK_EN
        else if (m_state == 2 && io_mon_write && !io_mon_waitrequest) begin
            m_state <= 3;
            m_ea    <= io_mon_address;
            m_ei    <= m_count;
        end
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        chk("busy",     32'(io_busy),      32'(m_state == 1));
        chk("done",     32'(io_done),      32'(m_state == 2));
        chk("error",    32'(io_error),     32'(m_state == 3));
        chk("errAddr",  io_errAddr,        m_ea);
        chk("errIndex", 32'(io_errIndex),  32'(m_ei));
        chk("dbgInfo",  32'(io___dbgInfo), 32'(model_dbg()));
    end

    task automatic cyc(input logic st, input logic [31:0] b, input logic [15:0] n,
                       input logic wr, input logic wt, input logic [31:0] a);
        io_start = st; io_cfg_base = b; io_cfg_count = n;
        io_mon_write = wr; io_mon_waitrequest = wt; io_mon_address = a;
        @(negedge clock);
    endtask

    task automatic beat(input logic [31:0] a);
        cyc(1'b0, 32'hDEAD_BEEF, 16'd77, 1'b1, 1'b0, a);
    endtask

    // Literal expectation pinned on both the DUT and the model.
    task automatic lit(input string name, input logic [4:0] dbg);
        chk({name, "_dut"},   32'(io___dbgInfo), 32'(dbg));
        chk({name, "_model"}, 32'(model_dbg()),  32'(dbg));
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        lit("rst_dbg", 5'b00000);
        chk("rst_flags", 32'({io_busy, io_done, io_error}), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Sequential run of 4 beats
        cyc(1'b1, 32'h1000, 16'd4, 1'b0, 1'b0, 32'h0);
        lit("t1_armed", 5'b01000);
        beat(32'h1000); lit("t1_b0", 5'b01001);
        beat(32'h1008); lit("t1_b1", 5'b01010);
        beat(32'h1010); lit("t1_b2", 5'b01011);
        beat(32'h1018); lit("t1_b3", 5'b10100);
        chk("t1_done", 32'(io_done), 32'd1);

        // Same run with a 3-cycle stall on beat 2
        cyc(1'b1, 32'h1000, 16'd4, 1'b0, 1'b0, 32'h0);
        beat(32'h1000);
        beat(32'h1008);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 16'd0, 1'b1, 1'b1, 32'h1010);
            lit("t2_stall", 5'b01010);
        end
        beat(32'h1010);
        beat(32'h1018);
        lit("t2_end", 5'b10100);
        chk("t2_noerr", 32'(io_error), 32'd0);

        // Mismatch on third beat
        cyc(1'b1, 32'h2000, 16'd8, 1'b0, 1'b0, 32'h0);
        beat(32'h2000);
        beat(32'h2008);
        beat(32'h2018);
        lit("t3_err", 5'b11010);
        chk("t3_errAddr", io_errAddr, 32'h2018);
        chk("t3_errIndex", 32'(io_errIndex), 32'd2);
        beat(32'h2010);
        chk("t3_hold", io_errAddr, 32'h2018);

        // Address wrap; re-arm from ERROR clears capture
        cyc(1'b1, 32'hFFFF_FFF8, 16'd2, 1'b0, 1'b0, 32'h0);
        chk("t4_clr", io_errAddr, 32'h0);
        beat(32'hFFFF_FFF8);
        beat(32'h0000_0000);
        chk("t4_done", 32'(io_done), 32'd1);
        lit("t4_dbg", 5'b10010);

        // Count zero
        cyc(1'b1, 32'h3000, 16'd0, 1'b0, 1'b0, 32'h0);
        lit("t5_zero", 5'b10000);

        // Asynchronous reset mid-run at index 3
        cyc(1'b1, 32'h40, 16'd8, 1'b0, 1'b0, 32'h0);
        beat(32'h40); beat(32'h48); beat(32'h50);
        lit("t6_run", 5'b01011);
        #2 reset = 1'b1;
        #1;
        chk("t6_async", 32'({io_busy, io_done, io_error, io___dbgInfo}), 32'd0);
        chk("t6_async_ea", io_errAddr, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Overrun after DONE with count 1
        cyc(1'b1, 32'h100, 16'd1, 1'b0, 1'b0, 32'h0);
        beat(32'h100);
        lit("t7_done", 5'b10001);
        beat(32'h108);
`ifdef WAV_OVERRUN_CHECK_EN
        chk("t7_ovr_err", 32'(io_error), 32'd1);
        chk("t7_ovr_idx", 32'(io_errIndex), 32'd1);
        lit("t7_ovr_dbg", 5'b11001);
`else
        chk("t7_ovr_done", 32'(io_done), 32'd1);
        lit("t7_ovr_dbg", 5'b10001);
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 199) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            io_start           = ($urandom_range(0, 99) < 6);
            io_cfg_count       = 16'($urandom_range(0, 9));
            io_cfg_base        = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                             : 32'($urandom);
            io_mon_write       = ($urandom_range(0, 3) != 0);
            io_mon_waitrequest = ($urandom_range(0, 3) == 0);
            io_mon_address     = ($urandom_range(0, 19) == 0) ? 32'($urandom) : model_exp();
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/write_address_verifier.md
# write_address_verifier

Monitors the Avalon-MM write channel of the memory-writing master and checks that accepted write beats hit a strictly sequential address run from a configured base. Sits directly upstream of the Avalon debug readout block: its registered 5-bit status code `io___dbgInfo` is the value that block timestamps and logs on every change. Also raises busy/done/error flags and captures the first offending address for software.

## Interface
Parameters:
- ADDR_W, 32, width of monitored address and base.
- STRIDE, 8, byte increment between consecutive expected addresses; power of two, at least 1.
- CNT_W, 16, width of beat count and index.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- io_cfg_base  in  ADDR_W  first expected address; sampled on start.
- io_cfg_count  in  CNT_W  number of beats expected; sampled on start.
- io_start  in  1  one-cycle arm pulse.
- io_mon_address  in  ADDR_W  monitored master address.
- io_mon_write  in  1  monitored write strobe.
- io_mon_waitrequest  in  1  monitored slave waitrequest.
- io_busy  out  1  state is RUN.
- io_done  out  1  state is DONE.
- io_error  out  1  state is ERROR.
- io_errAddr  out  ADDR_W  address of the first mismatching beat.
- io_errIndex  out  CNT_W  beat index at which the mismatch occurred.
- io___dbgInfo  out  5  status code; encoding given under Operation.

## Operation
- Accepted beat: `io_mon_write && !io_mon_waitrequest` in a cycle. Stalled cycles are never checked.
- States: IDLE(00), RUN(01), DONE(10), ERROR(11).
- IDLE + start:
  - If count is 0, go to DONE.
  - Otherwise go to RUN, with expected address = base and index = 0.
- RUN + accepted beat, address equals expected:
  - index is incremented.
  - expected address is incremented by STRIDE, wrapping modulo 2^ADDR_W.
  - If the new index equals count, go to DONE.
- RUN + accepted beat, address mismatch:
  - Go to ERROR.
  - Capture errAddr = observed address and errIndex = current index. Both hold until the next start.
- Start while in RUN is ignored.
- Start while in DONE or ERROR re-arms exactly as from IDLE and clears errAddr and errIndex to 0.
- io___dbgInfo = {state[1:0], index[2:0]}. The code therefore changes on every matched beat and on every state transition.
- Reset: state IDLE; busy, done, error = 0; errAddr, errIndex, index, expected address = 0; io___dbgInfo = 0.

## Timing
- All outputs are registered.
- A flag or code update appears one cycle after the accepted beat or start that causes it.
- An accepted beat in the same cycle as an IDLE start is not checked. Checking begins the cycle after start.
- The final matched beat and the DONE transition occur on the same edge: io_done rises one cycle after the last beat.
- Back-to-back accepted beats (one per cycle) are sustained with no bubbles.
- Reset asserted mid-RUN aborts immediately. No partial state survives.

## Configuration
- WAV_OVERRUN_CHECK_EN defined:
  - An accepted beat in DONE moves to ERROR.
  - errAddr is captured with that beat's address and errIndex = count.
- WAV_OVERRUN_CHECK_EN undefined: beats in DONE and IDLE are ignored.

## Test plan
- Base 0x1000, count 4, beats at 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles -> dbgInfo 01000, 01001, 01010, 01011, then 10100; done=1 one cycle after the 4th beat.
- Same run with waitrequest high for 3 cycles on beat 2 (address 0x1010 held) -> no check during the stall; completes at 10100 with error=0.
- Base 0x2000, count 8, third beat at 0x2018 -> error=1, errAddr=0x2018, errIndex=2, dbgInfo=11010; later beats are ignored.
- Base 0xFFFFFFF8, count 2, beats at 0xFFFFFFF8 then 0x00000000 -> done=1 (wrap accepted).
- Count 0 start -> done=1 next cycle, dbgInfo=10000. Reset asserted mid-run at index 3 -> all outputs 0 asynchronously.
- Overrun beat after DONE for count 1 -> with the macro: error=1, errIndex=1. Without the macro: done stays 1.
